// File: rtl/fft_bfly_combine.sv
// Radix-2 butterfly combine: aligns the upper operand A against the twiddle
// multiplier's W*B through a small FIFO, then registers A+W*B and A-W*B.
module fft_bfly_combine #(
    parameter int    DATA_FFT_SIZE = 16,
    parameter int    WB_SIZE       = 16,
    parameter int    FIFO_DEPTH    = 8,
    parameter string SCALE         = "grow",
    parameter string TYPE          = "forvard",
    localparam int   OUT_W         = (SCALE == "half") ? WB_SIZE : WB_SIZE + 1,
    localparam int   LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic [DATA_FFT_SIZE-1:0] a_i,
    input  logic [DATA_FFT_SIZE-1:0] a_q,
    input  logic                     wb_valid,
    input  logic [WB_SIZE-1:0]       wb_i,
    input  logic [WB_SIZE-1:0]       wb_q,
    output logic [OUT_W-1:0]         x0_i,
    output logic [OUT_W-1:0]         x0_q,
    output logic [OUT_W-1:0]         x1_i,
    output logic [OUT_W-1:0]         x1_q,
    output logic                     out_valid,
    output logic [LVL_W-1:0]         fifo_level,
    output logic                     err_ovf,
    output logic                     err_unf
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int SW  = WB_SIZE + 1;
    localparam bit INV = (TYPE == "invers");

    function automatic logic signed [SW-1:0] sext_a(input logic [DATA_FFT_SIZE-1:0] v);
        return SW'($signed(v));
    endfunction

    function automatic logic signed [SW-1:0] sext_wb(input logic [WB_SIZE-1:0] v);
        return SW'($signed(v));
    endfunction

    // "half" rounds half toward +inf; one extra bit keeps s+1 from wrapping
    function automatic logic [OUT_W-1:0] scale_out(input logic signed [SW-1:0] s);
        logic signed [SW:0] t;
        t = (SW+1)'(s) + (SW+1)'(1);
        if (SCALE == "half")
            return OUT_W'(t >>> 1);
        return OUT_W'(s);
    endfunction

    logic [2*DATA_FFT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic                       push;
    logic                       pop;
    logic [2*DATA_FFT_SIZE-1:0] head_p0;
    logic signed [SW-1:0]       s0_i_p0;
    logic signed [SW-1:0]       s0_q_p0;
    logic signed [SW-1:0]       s1_i_p0;
    logic signed [SW-1:0]       s1_q_p0;

    // No bypass: a push into an empty FIFO cannot serve a same-cycle pop
    assign pop  = wb_valid && (fifo_level != '0);
    assign push = a_valid && ((fifo_level < LVL_W'(FIFO_DEPTH)) || pop);

    // Stage p0: oldest A meets W*B in the pop cycle
    assign head_p0 = mem[rd_ptr];
    assign s0_i_p0 = sext_a(head_p0[2*DATA_FFT_SIZE-1:DATA_FFT_SIZE]) + sext_wb(wb_i);
    assign s0_q_p0 = sext_a(head_p0[DATA_FFT_SIZE-1:0]) + sext_wb(wb_q);
    assign s1_i_p0 = sext_a(head_p0[2*DATA_FFT_SIZE-1:DATA_FFT_SIZE]) - sext_wb(wb_i);
    assign s1_q_p0 = sext_a(head_p0[DATA_FFT_SIZE-1:0]) - sext_wb(wb_q);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {a_i, a_q};
    end

    // Stage p1: registered results and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
            out_valid  <= 1'b0;
            x0_i       <= '0;
            x0_q       <= '0;
            x1_i       <= '0;
            x1_q       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - LVL_W'(1);
            if (a_valid && !push)
                err_ovf <= 1'b1;
            if (wb_valid && !pop)
                err_unf <= 1'b1;
            out_valid <= pop;
            if (pop) begin
                if (INV) begin
                    x0_i <= scale_out(s1_i_p0);
                    x0_q <= scale_out(s1_q_p0);
                    x1_i <= scale_out(s0_i_p0);
                    x1_q <= scale_out(s0_q_p0);
                end else begin
                    x0_i <= scale_out(s0_i_p0);
                    x0_q <= scale_out(s0_q_p0);
                    x1_i <= scale_out(s1_i_p0);
                    x1_q <= scale_out(s1_q_p0);
                end
            end
        end
    end

endmodule
